// File: rtl/nabp_filtered_line_sink_pkg.sv
// Shared definitions for the NABP filtered-line sink.
//   kFilteredDataLength : default width of a filtered sample
//   kAstErrNone         : Avalon-ST error code meaning "beat is good"
//   sink_state_t        : line framing FSM states
package nabp_filtered_line_sink_pkg;

    localparam int kFilteredDataLength = 16;

    localparam logic [1:0] kAstErrNone = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        FLUSH = 2'd2
    } sink_state_t;

endpackage

// File: rtl/nabp_stream_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, reset : clock, asynchronous active-high reset (pointers/count only)
//   push       : write push_data (ignored while full)
//   pop        : drop the head entry (ignored while empty)
//   head_data  : current head entry, zero while empty
//   full/empty : occupancy flags
//   count      : number of stored entries (0..DEPTH)
module nabp_stream_fifo
    import nabp_filtered_line_sink_pkg::*;
#(
    parameter int WIDTH = kFilteredDataLength + 1,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is not reset; stale contents are never visible because
    // head_data is forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = empty ? '0 : mem[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/nabp_filtered_line_sink.sv
// Avalon-ST sink for the NABP filter output. Buffers filtered samples in a
// FWFT FIFO, frames them into LINE_LEN-sample projection lines and hands
// them downstream with an end-of-line tag, a line index and sticky error.
//   clk, reset        : clock, asynchronous active-high reset
//   enable            : arms reception of the next line
//   ast_sink_*        : Avalon-ST input (ready latency 0)
//   out_data/valid/last/ready : buffered output stream, out_last ends a line
//   line_idx          : index of the line currently being drained
//   line_done         : one-cycle pulse after a line's last sample is taken
//   err_flag          : sticky, set by any accepted beat with nonzero error
module nabp_filtered_line_sink
    import nabp_filtered_line_sink_pkg::*;
#(
    parameter int DATA_W     = kFilteredDataLength,
    parameter int LINE_LEN   = 256,
    parameter int FIFO_DEPTH = 8,
    parameter int IDX_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] ast_sink_data,
    input  logic              ast_sink_valid,
    input  logic [1:0]        ast_sink_error,
    output logic              ast_sink_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  line_idx,
    output logic              line_done,
    output logic              err_flag
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(LINE_LEN);

    sink_state_t       state_reg;
    sink_state_t       state_next;
    logic [BW-1:0]     beat_cnt_reg;
    logic [IDX_W-1:0]  line_idx_reg;
    logic              line_done_reg;
    logic              err_flag_reg;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [DATA_W:0]   fifo_head;

    logic              in_accept;
    logic              out_accept;
    logic              beat_is_last;
    logic              flush_done;

    assign in_accept    = ast_sink_valid && ast_sink_ready;
    assign out_accept   = out_valid && out_ready;
    assign beat_is_last = (beat_cnt_reg == BW'(LINE_LEN - 1));

    nabp_stream_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_accept),
        .push_data ({beat_is_last, ast_sink_data}),
        .pop       (out_accept),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_data  = fifo_head[DATA_W-1:0];
    assign out_last  = fifo_head[DATA_W];
    assign out_valid = !fifo_empty;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable) state_next = RECV;
            RECV:    if (in_accept && beat_is_last) state_next = FLUSH;
            FLUSH:   if (flush_done) state_next = enable ? RECV : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs. Input is blocked during FLUSH, so the only entry left
    // when the tagged last sample is popped is that sample itself.
    always_comb begin
        ast_sink_ready = (state_reg == RECV) && !fifo_full;
        flush_done     = (state_reg == FLUSH) && out_accept && out_last &&
                         (fifo_count == CW'(1));
    end

    // Beat counter, line index, line-done pulse and sticky error capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt_reg  <= '0;
            line_idx_reg  <= '0;
            line_done_reg <= 1'b0;
            err_flag_reg  <= 1'b0;
        end else begin
            if (in_accept) begin
                beat_cnt_reg <= beat_is_last ? '0 : beat_cnt_reg + 1'b1;
                if (ast_sink_error != kAstErrNone) begin
                    err_flag_reg <= 1'b1;
                end
            end
            line_done_reg <= flush_done;
            if (flush_done) begin
                line_idx_reg <= line_idx_reg + 1'b1;
            end
        end
    end

    assign line_idx  = line_idx_reg;
    assign line_done = line_done_reg;
    assign err_flag  = err_flag_reg;

endmodule

// File: tb/tb_nabp_filtered_line_sink.sv
// Scoreboard bench: two sinks (LINE_LEN 4 and 16, FIFO_DEPTH 8). Accepted
// input beats push the expected {data,last} into a per-instance queue; a
// negedge monitor pops and compares on every output handshake and checks
// line_idx, line_done, err_flag and out_valid against a line/beat model.
module tb_nabp_filtered_line_sink;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int IW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable  [2];
    logic [DW-1:0] s_data  [2];
    logic          s_valid [2];
    logic [1:0]    s_err   [2];
    logic          s_ready [2];
    logic [DW-1:0] o_data  [2];
    logic          o_valid [2];
    logic          o_last  [2];
    logic          o_ready [2];
    logic [IW-1:0] l_idx   [2];
    logic          l_done  [2];
    logic          e_flag  [2];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    bit lat_chk [2];
    bit rnd_done;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0d required=%0d t=%0t", name, k, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int LL = (gi == 0) ? 4 : 16;

        nabp_filtered_line_sink #(
            .DATA_W(DW), .LINE_LEN(LL), .FIFO_DEPTH(DEPTH), .IDX_W(IW)
        ) dut (
            .clk            (clk),
            .reset          (reset),
            .enable         (enable[gi]),
            .ast_sink_data  (s_data[gi]),
            .ast_sink_valid (s_valid[gi]),
            .ast_sink_error (s_err[gi]),
            .ast_sink_ready (s_ready[gi]),
            .out_data       (o_data[gi]),
            .out_valid      (o_valid[gi]),
            .out_last       (o_last[gi]),
            .out_ready      (o_ready[gi]),
            .line_idx       (l_idx[gi]),
            .line_done      (l_done[gi]),
            .err_flag       (e_flag[gi])
        );

        typedef struct {
            logic [DW-1:0] data;
            logic          last;
            int            cyc;
        } exp_t;

        exp_t sb [$];
        exp_t e;
        int   n_acc   = 0;
        int   n_lines = 0;
        bit   err_m   = 0;
        bit   done_m  = 0;

        always @(negedge clk) begin
            if (reset) begin
                sb.delete();
                n_acc   = 0;
                n_lines = 0;
                err_m   = 0;
                done_m  = 0;
            end else begin
                chk("line_idx", gi, 32'(l_idx[gi]), 32'(n_lines % 256));
                chk("line_done", gi, 32'(l_done[gi]), 32'(done_m));
                chk("err_flag", gi, 32'(e_flag[gi]), 32'(err_m));
                chk("out_valid", gi, 32'(o_valid[gi]), 32'(sb.size() != 0));
                if (s_ready[gi]) chk("ready_room", gi, 32'(sb.size() < DEPTH), 32'd1);
                done_m = 0;
                if (o_valid[gi] && o_ready[gi]) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_out dut%0d actual=%0d required=none t=%0t", gi, o_data[gi], $time);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", gi, 32'(o_data[gi]), 32'(e.data));
                        chk("out_last", gi, 32'(o_last[gi]), 32'(e.last));
                        if (lat_chk[gi]) chk("latency", gi, 32'(cycle - e.cyc), 32'd1);
                        if (e.last) begin
                            n_lines++;
                            done_m = 1;
                        end
                    end
                end
                if (s_valid[gi] && s_ready[gi]) begin
                    sb.push_back('{s_data[gi], ((n_acc % LL) == LL - 1), cycle});
                    n_acc++;
                    if (s_err[gi] != 2'b00) err_m = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and hold it until accepted (bounded).
    task automatic send(input int k, input logic [DW-1:0] d, input logic [1:0] er);
        bit acc;
        s_data[k]  = d;
        s_err[k]   = er;
        s_valid[k] = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            acc = s_ready[k];
            tick();
            if (acc) break;
            if (i == 299) chk("send_timeout", k, 32'd1, 32'd0);
        end
        s_valid[k] = 1'b0;
        s_err[k]   = 2'b00;
    endtask

    task automatic drain(input int k);
        o_ready[k] = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!o_valid[k]) break;
            if (i == 299) chk("drain_timeout", k, 32'd1, 32'd0);
        end
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog dut0 actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            enable[k] = 0; s_data[k] = '0; s_valid[k] = 0; s_err[k] = 0; o_ready[k] = 0; lat_chk[k] = 0;
        end
        tick();
        tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", k, 32'(s_ready[k]), 0);
            chk("rst_valid", k, 32'(o_valid[k]), 0);
            chk("rst_last", k, 32'(o_last[k]), 0);
            chk("rst_data", k, 32'(o_data[k]), 0);
            chk("rst_idx", k, 32'(l_idx[k]), 0);
            chk("rst_done", k, 32'(l_done[k]), 0);
            chk("rst_err", k, 32'(e_flag[k]), 0);
        end
        tick();
        reset = 1'b0;

        // Line of 1..4 streamed at full rate
        enable[0] = 1; o_ready[0] = 1; lat_chk[0] = 1;
        for (int i = 1; i <= 4; i++) send(0, 16'(i), 2'b00);
        @(negedge clk);
        chk("ready_in_flush", 0, 32'(s_ready[0]), 0);
        drain(0);
        lat_chk[0] = 0;
        chk("idx_after_line1", 0, 32'(l_idx[0]), 1);

        // Error beat mid-line, then a clean line: flag must stay set
        send(0, 16'h0100, 2'b00);
        send(0, 16'h0101, 2'b01);
        send(0, 16'h0102, 2'b00);
        send(0, 16'h0103, 2'b00);
        for (int i = 0; i < 4; i++) send(0, 16'(16'h0200 + i), 2'b00);
        drain(0);
        chk("err_sticky", 0, 32'(e_flag[0]), 1);

        // Reset with 3 entries buffered
        o_ready[0] = 0;
        for (int i = 0; i < 3; i++) send(0, 16'(16'h0300 + i), 2'b10);
        @(negedge clk);
        chk("buffered_before_rst", 0, 32'(o_valid[0]), 1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("rst_mid_valid", 0, 32'(o_valid[0]), 0);
        chk("rst_mid_err", 0, 32'(e_flag[0]), 0);
        chk("rst_mid_idx", 0, 32'(l_idx[0]), 0);
        @(negedge clk);
        tick();
        reset = 1'b0;

        // Random valid/ready gaps over 3 lines
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send(0, 16'($urandom), 2'b00);
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    o_ready[0] = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        drain(0);
        chk("idx_after_random", 0, 32'(l_idx[0]), 3);

        // enable dropped mid-line: line completes, then IDLE
        send(0, 16'h0401, 2'b00);
        send(0, 16'h0402, 2'b00);
        enable[0] = 0;
        send(0, 16'h0403, 2'b00);
        send(0, 16'h0404, 2'b00);
        drain(0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_ready", 0, 32'(s_ready[0]), 0);
        end
        tick();
        enable[0] = 1;
        for (int i = 0; i < 4; i++) send(0, 16'(16'h0500 + i), 2'b00);
        drain(0);
        chk("idx_after_reenable", 0, 32'(l_idx[0]), 5);

        // Backpressure on the 16-sample instance: exactly 8 accepted
        begin
            int n;
            n = 0;
            enable[1] = 1; o_ready[1] = 0; s_valid[1] = 1; s_data[1] = 16'd10;
            for (int i = 0; i < 14; i++) begin
                @(negedge clk);
                if (s_ready[1]) n++;
                tick();
                s_data[1] = 16'(10 + n);
            end
            s_valid[1] = 0;
            chk("accepted_until_full", 1, 32'(n), 8);
        end
        @(negedge clk);
        chk("ready_when_full", 1, 32'(s_ready[1]), 0);
        tick();
        o_ready[1] = 1;
        @(negedge clk);
        chk("ready_before_pop", 1, 32'(s_ready[1]), 0);
        @(negedge clk);
        chk("ready_after_pop", 1, 32'(s_ready[1]), 1);
        tick();
        for (int i = 18; i <= 25; i++) send(1, 16'(i), 2'b00);
        drain(1);
        chk("idx_after_bp_line", 1, 32'(l_idx[1]), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
